// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU datapath, the debug read port, the memory array
// and mem_port_arbiter. The arbiter uses the slave view; requesters/memory use master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic [15:0]   stat_cpu_cnt;
    logic [15:0]   stat_dbg_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, stat_cpu_cnt, stat_dbg_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, stat_cpu_cnt, stat_dbg_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: CPU-priority with anti-starvation for the debug read port.
// Define MEM_ARB_STATS_EN to build the per-port saturating grant counters.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_cpu,
    input  logic               rst_cpu,
    mem_port_arbiter_if.slave  bus
);
    localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           owner_dbg_q, owner_dbg_d;
    logic           we_q, we_d;
    logic           cpu_rvalid_q, cpu_rvalid_d;
    logic           dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0]  cpu_rdata_q, dbg_rdata_q;

    logic           cpu_gnt, dbg_gnt, mem_en, mem_we, dbg_wins;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;

    assign dbg_wins = bus.dbg_req && (!bus.cpu_req || (starve_q == SCW'(STARVE_MAX)));

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_dbg_d  = owner_dbg_q;
        we_d         = we_q;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_gnt      = 1'b0;
        dbg_gnt      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so they must be masked while reset is held.
                if ((bus.cpu_req || bus.dbg_req) && !rst_cpu) begin
                    mem_en    = 1'b1;
                    state_d   = WAIT;
                    lat_cnt_d = LCW'(MEM_LAT - 1);
                    if (dbg_wins) begin
                        dbg_gnt     = 1'b1;
                        mem_addr    = bus.dbg_addr;
                        owner_dbg_d = 1'b1;
                        we_d        = 1'b0;
                    end else begin
                        cpu_gnt     = 1'b1;
                        mem_we      = bus.cpu_we;
                        mem_addr    = bus.cpu_addr;
                        mem_wdata   = bus.cpu_wdata;
                        owner_dbg_d = 1'b0;
                        we_d        = bus.cpu_we;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d      = IDLE;
                    dbg_rvalid_d = owner_dbg_q;
                    cpu_rvalid_d = !owner_dbg_q;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (!bus.dbg_req || dbg_gnt) begin
            starve_d = '0;
        end else if (cpu_gnt && (starve_q != SCW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_q     <= '0;
            owner_dbg_q  <= 1'b0;
            we_q         <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_q     <= starve_d;
            owner_dbg_q  <= owner_dbg_d;
            we_q         <= we_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            if (cpu_rvalid_d && !we_q) cpu_rdata_q <= bus.mem_rdata;
            if (dbg_rvalid_d)          dbg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.busy       = (state_q == WAIT);

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_cpu_q, stat_dbg_q;

    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            stat_cpu_q <= '0;
            stat_dbg_q <= '0;
        end else begin
            if (cpu_gnt && (stat_cpu_q != 16'hFFFF)) stat_cpu_q <= stat_cpu_q + 16'd1;
            if (dbg_gnt && (stat_dbg_q != 16'hFFFF)) stat_dbg_q <= stat_dbg_q + 16'd1;
        end
    end

    assign bus.stat_cpu_cnt = stat_cpu_q;
    assign bus.stat_dbg_cnt = stat_dbg_q;
`else
    assign bus.stat_cpu_cnt = 16'h0;
    assign bus.stat_dbg_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance, each with a
// latency-accurate memory responder; directed scenarios plus randomized traffic vs a model.
module tb_mem_port_arbiter;
    localparam int SMAX = 4;
    localparam int LAT1 = 1;

    logic clk_cpu = 1'b0;
    logic rst_cpu = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_cpu = ~clk_cpu;

    mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
        .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .bus(b1.slave));
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
        .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .bus(b3.slave));

    // Memory responders: data is only valid exactly MEM_LAT cycles after issue.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [5:0]  rd1, rd3;
    int          age1, age3;

    always @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 32'hA500_0000 + i;
                mem3[i] <= 32'hA500_0000 + i;
            end
            mem1[4] <= 32'hDEAD_BEEF;
            mem3[4] <= 32'hDEAD_BEEF;
            age1 <= 0; age3 <= 0; rd1 <= '0; rd3 <= '0;
        end else begin
            if (b1.mem_en) begin
                if (b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
                rd1 <= b1.mem_addr[7:2];
                age1 <= 1;
            end else if (age1 != 0 && age1 < 1000) age1 <= age1 + 1;
            if (b3.mem_en) begin
                if (b3.mem_we) mem3[b3.mem_addr[7:2]] <= b3.mem_wdata;
                rd3 <= b3.mem_addr[7:2];
                age3 <= 1;
            end else if (age3 != 0 && age3 < 1000) age3 <= age3 + 1;
        end
    end

    assign b1.mem_rdata = (age1 == 1) ? mem1[rd1] : 32'hBAD0_BAD0;
    assign b3.mem_rdata = (age3 == 3) ? mem3[rd3] : 32'hBAD0_BAD0;

    typedef struct {
        int          at;
        bit          dbg;
        bit          we;
        logic [31:0] data;
    } comp_t;

    task automatic clear_inputs();
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.dbg_req = 0; b1.dbg_addr = '0;
        b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
        b3.dbg_req = 0; b3.dbg_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_cpu = 1'b1;
        repeat (2) @(negedge clk_cpu);
        rst_cpu = 1'b0;
    endtask

    task automatic test_reset();
        logic [166:0] v1, v3;
        clear_inputs();
        #1 rst_cpu = 1'b1;
        b1.cpu_req = 1; b1.dbg_req = 1; b3.cpu_req = 1;
        b1.cpu_addr = 32'h44; b1.cpu_wdata = 32'h5555_AAAA;
        @(negedge clk_cpu); #1;
        v1 = {b1.cpu_gnt, b1.dbg_gnt, b1.cpu_rvalid, b1.dbg_rvalid, b1.busy, b1.mem_en, b1.mem_we,
              b1.mem_addr, b1.mem_wdata, b1.cpu_rdata, b1.dbg_rdata, b1.stat_cpu_cnt, b1.stat_dbg_cnt};
        v3 = {b3.cpu_gnt, b3.dbg_gnt, b3.cpu_rvalid, b3.dbg_rvalid, b3.busy, b3.mem_en, b3.mem_we,
              b3.mem_addr, b3.mem_wdata, b3.cpu_rdata, b3.dbg_rdata, b3.stat_cpu_cnt, b3.stat_dbg_cnt};
        n_checks++; if (v1 !== '0) begin n_fail++; $display("FAIL reset_outs_lat1: got %h want 0", v1); end
        n_checks++; if (v3 !== '0) begin n_fail++; $display("FAIL reset_outs_lat3: got %h want 0", v3); end
        clear_inputs();
        @(negedge clk_cpu);
        rst_cpu = 1'b0;
    endtask

    task automatic test_cpu_read();
        do_reset();
        @(negedge clk_cpu);
        b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h10; b1.cpu_wdata = 32'h0;
        #1;
        n_checks++; if ({b1.cpu_gnt, b1.dbg_gnt, b1.mem_en, b1.mem_we, b1.busy} !== 5'b10100) begin
            n_fail++; $display("FAIL rd_issue_ctl: got %b want 10100", {b1.cpu_gnt, b1.dbg_gnt, b1.mem_en, b1.mem_we, b1.busy}); end
        n_checks++; if (b1.mem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_issue_addr: got %h want 10", b1.mem_addr); end
        @(negedge clk_cpu);
        b1.cpu_req = 0; b1.cpu_addr = 32'hFC;
        #1;
        n_checks++; if ({b1.busy, b1.cpu_gnt, b1.mem_en, b1.cpu_rvalid} !== 4'b1000) begin
            n_fail++; $display("FAIL rd_wait_ctl: got %b want 1000", {b1.busy, b1.cpu_gnt, b1.mem_en, b1.cpu_rvalid}); end
        @(negedge clk_cpu); #1;
        n_checks++; if ({b1.cpu_rvalid, b1.dbg_rvalid, b1.busy} !== 3'b100) begin
            n_fail++; $display("FAIL rd_rvalid_T2: got %b want 100", {b1.cpu_rvalid, b1.dbg_rvalid, b1.busy}); end
        n_checks++; if (b1.cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", b1.cpu_rdata); end
        n_checks++; if (b1.dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_dbg_untouched: got %h want 0", b1.dbg_rdata); end
        @(negedge clk_cpu); #1;
        n_checks++; if (b1.cpu_rvalid !== 1'b0 || b1.cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_pulse_hold: got rvalid=%b data=%h want 0/deadbeef", b1.cpu_rvalid, b1.cpu_rdata); end
    endtask

    task automatic test_cpu_write();
        @(negedge clk_cpu);
        b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h20; b1.cpu_wdata = 32'h1234_5678;
        #1;
        n_checks++; if ({b1.cpu_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== {3'b111, 32'h20, 32'h1234_5678}) begin
            n_fail++; $display("FAIL wr_issue: got %b %h %h want 111 20 12345678", {b1.cpu_gnt, b1.mem_en, b1.mem_we}, b1.mem_addr, b1.mem_wdata); end
        @(negedge clk_cpu);
        b1.cpu_req = 0; b1.cpu_we = 0;
        #1;
        n_checks++; if ({b1.mem_en, b1.mem_we, b1.busy} !== 3'b001) begin
            n_fail++; $display("FAIL wr_strobe_1cyc: got %b want 001", {b1.mem_en, b1.mem_we, b1.busy}); end
        @(negedge clk_cpu); #1;
        n_checks++; if (b1.cpu_rvalid !== 1'b1 || b1.cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_ack: got rvalid=%b data=%h want 1/deadbeef", b1.cpu_rvalid, b1.cpu_rdata); end
    endtask

    task automatic test_starvation();
        int  ngr;
        bit  want_dbg;
        do_reset();
        @(negedge clk_cpu);
        b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h10; b1.dbg_req = 1; b1.dbg_addr = 32'h40;
        ngr = 0;
        for (int k = 0; k < 60 && ngr < 10; k++) begin
            #1;
            n_checks++; if (b1.cpu_gnt && b1.dbg_gnt) begin n_fail++; $display("FAIL starve_dual_gnt: got both at step %0d want one", k); end
            if (b1.cpu_gnt || b1.dbg_gnt) begin
                want_dbg = (ngr % (SMAX + 1)) == SMAX;
                n_checks++; if (b1.dbg_gnt !== want_dbg) begin
                    n_fail++; $display("FAIL starve_seq[%0d]: got dbg_gnt=%b want %b", ngr, b1.dbg_gnt, want_dbg); end
                ngr++;
            end
            @(negedge clk_cpu);
        end
        n_checks++; if (ngr != 10) begin n_fail++; $display("FAIL starve_bound: got %0d grants want 10", ngr); end
        clear_inputs();
        repeat (3) @(negedge clk_cpu);
    endtask

    task automatic test_lat3();
        do_reset();
        @(negedge clk_cpu);
        b3.dbg_req = 1; b3.dbg_addr = 32'h40;
        #1;
        n_checks++; if ({b3.dbg_gnt, b3.cpu_gnt, b3.mem_en, b3.mem_we, b3.busy} !== 5'b10100 ||
                        b3.mem_addr !== 32'h40 || b3.mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL l3_issue: got %b %h %h want 10100 40 0",
                {b3.dbg_gnt, b3.cpu_gnt, b3.mem_en, b3.mem_we, b3.busy}, b3.mem_addr, b3.mem_wdata); end
        @(negedge clk_cpu);
        b3.dbg_req = 0; b3.dbg_addr = 32'hFC; b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h10;
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) @(negedge clk_cpu);
            #1;
            n_checks++; if ({b3.busy, b3.cpu_gnt, b3.mem_en, b3.dbg_rvalid} !== 4'b1000) begin
                n_fail++; $display("FAIL l3_busy_T%0d: got %b want 1000", t, {b3.busy, b3.cpu_gnt, b3.mem_en, b3.dbg_rvalid}); end
        end
        @(negedge clk_cpu); #1;
        n_checks++; if ({b3.dbg_rvalid, b3.busy, b3.cpu_gnt, b3.mem_en} !== 4'b1011 || b3.mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL l3_T4: got %b addr %h want 1011 10", {b3.dbg_rvalid, b3.busy, b3.cpu_gnt, b3.mem_en}, b3.mem_addr); end
        n_checks++; if (b3.dbg_rdata !== 32'hA500_0010) begin n_fail++; $display("FAIL l3_dbg_data: got %h want a5000010", b3.dbg_rdata); end
        @(negedge clk_cpu);
        b3.cpu_req = 0;
        #1;
        n_checks++; if (b3.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL l3_dbg_pulse: got %b want 0", b3.dbg_rvalid); end
        repeat (3) @(negedge clk_cpu);
        #1;
        n_checks++; if (b3.cpu_rvalid !== 1'b1 || b3.cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL l3_cpu_T8: got rvalid=%b data=%h want 1/deadbeef", b3.cpu_rvalid, b3.cpu_rdata); end
    endtask

    task automatic test_reset_mid_wait();
        logic [166:0] v3;
        do_reset();
        @(negedge clk_cpu);
        b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h10;
        #1;
        n_checks++; if (b3.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmw_issue: got %b want 1", b3.cpu_gnt); end
        @(negedge clk_cpu);
        b3.cpu_req = 0;
        rst_cpu = 1'b1;
        #1;
        v3 = {b3.cpu_gnt, b3.dbg_gnt, b3.cpu_rvalid, b3.dbg_rvalid, b3.busy, b3.mem_en, b3.mem_we,
              b3.mem_addr, b3.mem_wdata, b3.cpu_rdata, b3.dbg_rdata, b3.stat_cpu_cnt, b3.stat_dbg_cnt};
        n_checks++; if (v3 !== '0) begin n_fail++; $display("FAIL rmw_outs: got %h want 0", v3); end
        repeat (2) @(negedge clk_cpu);
        rst_cpu = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_cpu); #1;
            n_checks++; if ({b3.cpu_rvalid, b3.dbg_rvalid, b3.busy} !== 3'b000 || b3.cpu_rdata !== 32'h0) begin
                n_fail++; $display("FAIL rmw_aborted_%0d: got %b %h want 000 0", t, {b3.cpu_rvalid, b3.dbg_rvalid, b3.busy}, b3.cpu_rdata); end
        end
        @(negedge clk_cpu);
        b3.cpu_req = 1;
        #1;
        n_checks++; if (b3.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmw_regrant: got %b want 1", b3.cpu_gnt); end
        @(negedge clk_cpu);
        b3.cpu_req = 0;
        repeat (3) @(negedge clk_cpu);
        #1;
        n_checks++; if (b3.cpu_rvalid !== 1'b1 || b3.cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rmw_complete: got rvalid=%b data=%h want 1/deadbeef", b3.cpu_rvalid, b3.cpu_rdata); end
    endtask

    task automatic test_stats();
        logic [15:0] ec, ed;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_cpu);
            if (i < 3) begin b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h8; end
            else begin b1.dbg_req = 1; b1.dbg_addr = 32'hC; end
            @(negedge clk_cpu);
            b1.cpu_req = 0; b1.dbg_req = 0;
        end
        @(negedge clk_cpu); #1;
`ifdef MEM_ARB_STATS_EN
        ec = 16'd3; ed = 16'd2;
`else
        ec = 16'd0; ed = 16'd0;
`endif
        n_checks++; if (b1.stat_cpu_cnt !== ec) begin n_fail++; $display("FAIL stat_cpu: got %0d want %0d", b1.stat_cpu_cnt, ec); end
        n_checks++; if (b1.stat_dbg_cnt !== ed) begin n_fail++; $display("FAIL stat_dbg: got %0d want %0d", b1.stat_dbg_cnt, ed); end
    endtask

    task automatic test_random();
        comp_t       comp_q[$];
        comp_t       c;
        int          free_at, last_issue, starve, n_cg, n_dg;
        bit          cpend, dpend, cwe, eg_c, eg_d, ewe, erv_c, erv_d, ebusy;
        logic [31:0] caddr, cwdata, daddr, eaddr, ewd, exp_crd, exp_drd;
        logic [15:0] ec, ed;
        do_reset();
        free_at = 0; last_issue = -100; starve = 0; n_cg = 0; n_dg = 0;
        cpend = 0; dpend = 0; cwe = 0; caddr = 0; cwdata = 0; daddr = 0;
        exp_crd = 0; exp_drd = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_cpu);
            if (cyc < 392) begin
                if (!cpend && $urandom_range(0, 1) == 0) begin
                    cpend = 1; cwe = 1'($urandom_range(0, 1));
                    caddr = 32'($urandom_range(0, 63)) << 2; cwdata = $urandom;
                end else if (cpend && $urandom_range(0, 15) == 0) cpend = 0;
                if (!dpend && $urandom_range(0, 1) == 0) begin
                    dpend = 1; daddr = 32'($urandom_range(0, 63)) << 2;
                end else if (dpend && $urandom_range(0, 15) == 0) dpend = 0;
            end else begin
                cpend = 0; dpend = 0;
            end
            b1.cpu_req = cpend; b1.cpu_we = cwe; b1.cpu_addr = caddr; b1.cpu_wdata = cwdata;
            b1.dbg_req = dpend; b1.dbg_addr = daddr;
            #1;
            eg_c = 0; eg_d = 0; ewe = 0; eaddr = 0; ewd = 0;
            if (cyc >= free_at && (cpend || dpend)) begin
                if (dpend && (!cpend || starve == SMAX)) begin
                    eg_d = 1; eaddr = daddr;
                    comp_q.push_back('{cyc + LAT1 + 1, 1'b1, 1'b0, mem1[daddr[7:2]]});
                end else begin
                    eg_c = 1; eaddr = caddr; ewd = cwdata; ewe = cwe;
                    comp_q.push_back('{cyc + LAT1 + 1, 1'b0, cwe, mem1[caddr[7:2]]});
                end
                last_issue = cyc; free_at = cyc + LAT1 + 1;
            end
            if (!dpend || eg_d) starve = 0;
            else if (eg_c && starve < SMAX) starve++;
            erv_c = 0; erv_d = 0;
            if (comp_q.size() > 0 && comp_q[0].at == cyc) begin
                c = comp_q.pop_front();
                if (c.dbg) begin erv_d = 1; exp_drd = c.data; end
                else begin erv_c = 1; if (!c.we) exp_crd = c.data; end
            end
            ebusy = (cyc > last_issue) && (cyc < free_at);
            n_checks++; if ({b1.cpu_gnt, b1.dbg_gnt, b1.mem_en, b1.mem_we, b1.cpu_rvalid, b1.dbg_rvalid, b1.busy} !==
                            {eg_c, eg_d, eg_c | eg_d, ewe, erv_c, erv_d, ebusy}) begin
                n_fail++; $display("FAIL rnd_ctl@%0d: got %b want %b", cyc,
                    {b1.cpu_gnt, b1.dbg_gnt, b1.mem_en, b1.mem_we, b1.cpu_rvalid, b1.dbg_rvalid, b1.busy},
                    {eg_c, eg_d, eg_c | eg_d, ewe, erv_c, erv_d, ebusy}); end
            n_checks++; if (b1.mem_addr !== eaddr || b1.mem_wdata !== ewd) begin
                n_fail++; $display("FAIL rnd_bus@%0d: got %h/%h want %h/%h", cyc, b1.mem_addr, b1.mem_wdata, eaddr, ewd); end
            n_checks++; if (b1.cpu_rdata !== exp_crd || b1.dbg_rdata !== exp_drd) begin
                n_fail++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", cyc, b1.cpu_rdata, b1.dbg_rdata, exp_crd, exp_drd); end
            if (eg_c) begin cpend = 0; n_cg++; end
            if (eg_d) begin dpend = 0; n_dg++; end
        end
`ifdef MEM_ARB_STATS_EN
        ec = 16'(n_cg); ed = 16'(n_dg);
`else
        ec = 16'd0; ed = 16'd0;
`endif
        n_checks++; if (b1.stat_cpu_cnt !== ec || b1.stat_dbg_cnt !== ed) begin
            n_fail++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", b1.stat_cpu_cnt, b1.stat_dbg_cnt, ec, ed); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_starvation();
        test_lat3();
        test_reset_mid_wait();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
